priority_encoder8to3: RTL and testbench
=======================================

Name: priority_encoder8to3

Overview:
- Sequential 8-to-3 priority encoder. It is the return path of the team's 3-to-8 one-hot decoders.
- Each request line sets a bit in a pending register. The block serves pending bits one at a time, lowest index first.
- For each served bit it presents the 3-bit binary index on a valid/ready output channel, and clears the bit on handshake.
- Sits between one-hot event/request sources and a binary-indexed consumer (mux select, counter bank, or a downstream 3-to-8 decoder).

Parameters:
- WIDTH, 8, number of request lines; must be a power of two, minimum 2.
- IDX_W, $clog2(WIDTH) = 3, width of the encoded index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  request lines; each bit is a one-cycle or held request; multiple bits may be high.
- en  input  1  capture enable; din is ignored while low.
- dout  output  IDX_W  encoded index of the request currently presented.
- dout_valid  output  1  dout holds a served request.
- dout_ready  input  1  consumer accepts dout this cycle.
- pending  output  WIDTH  registered set of outstanding requests, including the one presented.
- busy  output  1  |pending.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pending=0, dout=0, dout_valid=0, state=IDLE, busy=0.
  - rst overrides every other input in the same cycle.
  - Reset mid-operation drops all pending requests and any presented index without a handshake.
- Capture rule, every edge: pending <= (pending & ~clr) | (en ? din : 0).
  - clr is the one-hot of dout when dout_valid & dout_ready; otherwise 0.
  - Set wins: a din bit equal to the index being accepted in the same cycle stays pending and is served again.
- Selection: lowest set bit of the selection vector wins. Bit 0 has highest priority.
- State IDLE:
  - dout_valid=0.
  - If pending!=0: dout <= index of lowest set bit of pending, dout_valid <= 1, go HOLD.
- State HOLD:
  - dout_valid=1.
  - dout and dout_valid are stable while dout_ready=0, even if a higher-priority request arrives.
  - On dout_ready=1, let rem = pending & ~clr:
    - if rem!=0: dout <= lowest set index of rem, stay HOLD. Back-to-back, one index per cycle.
    - else: dout_valid <= 0, go IDLE. dout keeps its last value.
  - din captured in the handshake cycle is not part of rem. It is considered from the next cycle.
- Latency: din bit asserted with en=1 at edge k into an empty block → pending bit set after edge k → dout_valid=1 after edge k+1. Two cycles.
- Throughput: one index per cycle when dout_ready is held high.
- pending always contains the bit currently presented on dout until its handshake edge.
- All outputs are registered except busy, which is combinational from pending.

Decomposition:
- Package enc_pkg:
  - localparams ENC_WIDTH=8 and ENC_IDX_W=3.
  - typedef enum logic {ENC_IDLE, ENC_HOLD} enc_state_t.
- Sub-module lsb_first_encoder, purely combinational.
  - Inputs: vec[WIDTH-1:0]. Outputs: idx[IDX_W-1:0], found.
  - Instantiated twice in the top: once on pending, once on rem.
- Top holds the pending register, the FSM and the output registers.

Test Plan:
1. Reset, then en=1, din=8'b0000_0100 for one cycle, dout_ready=1 → dout_valid rises 2 cycles later with dout=3'd2 for one cycle; pending returns to 0; busy falls.
2. din=8'b1010_0010 in one cycle, dout_ready=1 → dout sequence 1, 5, 7 on consecutive cycles, valid high for exactly 3 cycles.
3. Backpressure: din=8'b0000_1000, dout_ready=0 for 4 cycles, with din=8'b0000_0001 injected meanwhile → dout stays 3 throughout stall; after ready, sequence 3 then 0.
4. Set-wins collision: presenting dout=4 with dout_ready=1 while din=8'b0001_0000, en=1 → index 4 presented again on a later cycle; pending[4] never drops to 0 between.
5. en=0 with din=8'hFF → pending stays 0, dout_valid stays 0; existing pending bits still drain normally.
6. Reset mid-operation with pending=8'hF0, dout_valid=1, rst=1 for one cycle → next cycle pending=0, dout=0, dout_valid=0, busy=0, no handshake emitted.

Source files
------------

// File: rtl/priority_encoder8to3_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder.
//   ENC_WIDTH   : default number of request lines
//   ENC_IDX_W   : width of the encoded index
//   enc_state_t : serving FSM state (idle / holding a presented index)
package enc_pkg;

  localparam int unsigned ENC_WIDTH = 8;
  localparam int unsigned ENC_IDX_W = 3;

  typedef enum logic {
    ENC_IDLE,
    ENC_HOLD
  } enc_state_t;

endpackage

// File: rtl/priority_encoder8to3_lsb_first_encoder.sv
// Combinational lowest-set-bit encoder. Bit 0 has the highest priority.
//   vec   : input vector
//   idx   : index of the lowest set bit (0 when vec is empty)
//   found : vec has at least one set bit
module lsb_first_encoder #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // Scan from the top down so the lowest set bit is the last to write idx.
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/priority_encoder8to3.sv
// Sequential priority encoder: collects one-hot requests in a pending
// register and presents them one at a time, lowest index first, as a binary
// index on a valid/ready channel. A bit is cleared on its handshake.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   din        : request lines (captured when en=1)
//   en         : capture enable
//   dout       : index of the presented request
//   dout_valid : dout holds a served request
//   dout_ready : consumer accepts dout this cycle
//   pending    : outstanding requests, including the presented one
//   busy       : |pending
module priority_encoder8to3
  import enc_pkg::*;
#(
  parameter int unsigned WIDTH = ENC_WIDTH,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [IDX_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] pending,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rem;
  logic [IDX_W-1:0] pend_idx, rem_idx;
  logic             pend_found, rem_found;

  // One-hot of the index being accepted this cycle.
  assign clr = (dout_valid_q && dout_ready) ? (WIDTH'(1) << dout_q) : '0;

  // Requests left after this cycle's handshake; new din is excluded so it is
  // only considered from the next cycle onward.
  assign rem = pending_q & ~clr;

  lsb_first_encoder #(.WIDTH(WIDTH)) u_enc_pending (
    .vec   (pending_q),
    .idx   (pend_idx),
    .found (pend_found)
  );

  lsb_first_encoder #(.WIDTH(WIDTH)) u_enc_rem (
    .vec   (rem),
    .idx   (rem_idx),
    .found (rem_found)
  );

  always_comb begin
    // OR-ing din after the clear lets a re-request of the accepted index win.
    pending_d    = rem | (en ? din : '0);
    state_d      = state_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    unique case (state_q)
      ENC_IDLE: begin
        if (pend_found) begin
          dout_d       = pend_idx;
          dout_valid_d = 1'b1;
          state_d      = ENC_HOLD;
        end
      end
      ENC_HOLD: begin
        // Without ready the presented index is frozen, even if a
        // higher-priority request has arrived since.
        if (dout_ready) begin
          if (rem_found) begin
            dout_d = rem_idx;
          end else begin
            dout_valid_d = 1'b0;
            state_d      = ENC_IDLE;
          end
        end
      end
      default: begin
        state_d      = ENC_IDLE;
        dout_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENC_IDLE;
      pending_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign pending    = pending_q;
  assign busy       = |pending_q;

endmodule

// File: tb/tb_priority_encoder8to3.sv
module tb_priority_encoder8to3;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       en;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] pending;
  logic       busy;

  int unsigned vectors;
  int unsigned errors;

  priority_encoder8to3 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .pending    (pending),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and let outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic chk_all(input string tag, input logic [7:0] e_pend, input logic e_valid,
                         input logic [2:0] e_dout);
    chk({tag, ".pending"}, 32'(pending), 32'(e_pend));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".busy"}, 32'(busy), 32'(e_pend != 8'h00));
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    rst        = 1'b1;
    en         = 1'b0;
    din        = 8'h00;
    dout_ready = 1'b0;

    // Reset state
    tick();
    chk_all("reset", 8'h00, 1'b0, 3'd0);

    // 1: single request, two-cycle latency, one-cycle valid
    rst = 1'b0; en = 1'b1; din = 8'h04; dout_ready = 1'b1;
    tick(); chk_all("t1.cap", 8'h04, 1'b0, 3'd0);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t1.pres", 8'h04, 1'b1, 3'd2);
    tick(); chk_all("t1.done", 8'h00, 1'b0, 3'd2);

    // 2: 1010_0010 drains as 1, 5, 7 back-to-back
    en = 1'b1; din = 8'hA2;
    tick(); chk_all("t2.cap", 8'hA2, 1'b0, 3'd2);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t2.i1", 8'hA2, 1'b1, 3'd1);
    tick(); chk_all("t2.i5", 8'hA0, 1'b1, 3'd5);
    tick(); chk_all("t2.i7", 8'h80, 1'b1, 3'd7);
    tick(); chk_all("t2.done", 8'h00, 1'b0, 3'd7);

    // 3: backpressure with a higher-priority request arriving mid-stall
    dout_ready = 1'b0; en = 1'b1; din = 8'h08;
    tick(); chk_all("t3.cap", 8'h08, 1'b0, 3'd7);
    din = 8'h01;
    tick(); chk_all("t3.s1", 8'h09, 1'b1, 3'd3);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t3.s2", 8'h09, 1'b1, 3'd3);
    tick(); chk_all("t3.s3", 8'h09, 1'b1, 3'd3);
    dout_ready = 1'b1;
    tick(); chk_all("t3.i0", 8'h01, 1'b1, 3'd0);
    tick(); chk_all("t3.done", 8'h00, 1'b0, 3'd0);

    // 4: set wins over clear for the accepted index
    en = 1'b1; din = 8'h10;
    tick(); chk_all("t4.cap", 8'h10, 1'b0, 3'd0);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t4.p1", 8'h10, 1'b1, 3'd4);
    en = 1'b1; din = 8'h10;
    tick(); chk_all("t4.hs", 8'h10, 1'b0, 3'd4);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t4.p2", 8'h10, 1'b1, 3'd4);
    tick(); chk_all("t4.done", 8'h00, 1'b0, 3'd4);

    // 5: en=0 masks din; captured bits still drain
    en = 1'b0; din = 8'hFF;
    tick(); chk_all("t5.m1", 8'h00, 1'b0, 3'd4);
    tick(); chk_all("t5.m2", 8'h00, 1'b0, 3'd4);
    en = 1'b1; din = 8'h06;
    tick(); chk_all("t5.cap", 8'h06, 1'b0, 3'd4);
    en = 1'b0; din = 8'hFF;
    tick(); chk_all("t5.i1", 8'h06, 1'b1, 3'd1);
    tick(); chk_all("t5.i2", 8'h04, 1'b1, 3'd2);
    tick(); chk_all("t5.done", 8'h00, 1'b0, 3'd2);

    // 6: reset mid-operation overrides capture and handshake
    dout_ready = 1'b0; en = 1'b1; din = 8'hF0;
    tick(); chk_all("t6.cap", 8'hF0, 1'b0, 3'd2);
    en = 1'b0; din = 8'h00;
    tick(); chk_all("t6.pres", 8'hF0, 1'b1, 3'd4);
    rst = 1'b1; dout_ready = 1'b1; en = 1'b1; din = 8'hFF;
    tick(); chk_all("t6.rst", 8'h00, 1'b0, 3'd0);
    rst = 1'b0; en = 1'b0; din = 8'h00;
    tick(); chk_all("t6.after", 8'h00, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
